// File: rtl/pwm_phase_bank_pkg.sv
// Shared definitions for pwm_phase_bank: request encoding, default parameters and threshold sizing.
// The optional centre-aligned build (PWM_CENTER_ALIGNED_EN) relies on the same definitions.
package pwm_phase_bank_pkg;

  typedef enum logic [1:0] {
    REQ_OFF = 2'd0,
    REQ_HI  = 2'd1,
    REQ_LO  = 2'd2
  } req_t;

  localparam int DEF_NUM_PHASES    = 3;
  localparam int DEF_DUTY_WIDTH    = 9;
  localparam int DEF_COUNTER_WIDTH = 11;
  localparam int DEF_PERIOD        = 1024;
  localparam int DEF_DEAD_TIME     = 8;
  localparam int DEF_DUTY_STEP     = 2;

  // Width that holds both the largest raw duty*step product and PERIOD itself.
  function automatic int thr_width(int duty_width, int duty_step, int period);
    int max_prod;
    int max_val;
    max_prod = ((1 << duty_width) - 1) * duty_step;
    max_val  = (max_prod > period) ? max_prod : period;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pwm_phase_bank_if.sv
// Control/status bundle between the motor control loop and pwm_phase_bank.
// Same signal set whether or not PWM_CENTER_ALIGNED_EN is defined.
interface pwm_phase_bank_if
  import pwm_phase_bank_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int DUTY_WIDTH = DEF_DUTY_WIDTH
);

  logic [NUM_PHASES*DUTY_WIDTH-1:0] duty_in;
  logic                             duty_load;
  logic [NUM_PHASES-1:0]            phase_en;
  logic                             brake;
  logic [NUM_PHASES-1:0]            pwm_hi;
  logic [NUM_PHASES-1:0]            pwm_lo;
  logic                             period_start;

  modport master (
    output duty_in, duty_load, phase_en, brake,
    input  pwm_hi, pwm_lo, period_start
  );

  modport slave (
    input  duty_in, duty_load, phase_en, brake,
    output pwm_hi, pwm_lo, period_start
  );

endinterface

// File: rtl/pwm_dead_time.sv
// Single-phase dead-time inserter: any request change blanks both gates for DEAD_TIME cycles.
// Identical in edge-aligned and PWM_CENTER_ALIGNED_EN builds.
module pwm_dead_time
  import pwm_phase_bank_pkg::*;
#(
  parameter int DEAD_TIME = DEF_DEAD_TIME
) (
  input  logic clock,
  input  logic reset_n,
  input  req_t req,
  output logic hi,
  output logic lo
);

  // req_q   | meaning
  // REQ_OFF | coast, both gates off
  // REQ_HI  | high side drives once cnt has expired
  // REQ_LO  | low side drives once cnt has expired

  localparam int CW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(DEAD_TIME - 1);

  req_t          req_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_q <= REQ_OFF;
      cnt   <= CNT_INIT;
      hi    <= 1'b0;
      lo    <= 1'b0;
    end else if (req != req_q) begin
      req_q <= req;
      cnt   <= CNT_INIT;
      hi    <= 1'b0;
      lo    <= 1'b0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      hi  <= 1'b0;
      lo  <= 1'b0;
    end else begin
      hi <= (req_q == REQ_HI);
      lo <= (req_q == REQ_LO);
    end
  end

endmodule

// File: rtl/pwm_phase_bank.sv
// Multi-phase complementary PWM with shared period counter, shadowed duty and dead time.
// Define PWM_CENTER_ALIGNED_EN for a triangle counter with peak-centred pulses.
module pwm_phase_bank
  import pwm_phase_bank_pkg::*;
#(
  parameter int NUM_PHASES    = DEF_NUM_PHASES,
  parameter int DUTY_WIDTH    = DEF_DUTY_WIDTH,
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int PERIOD        = DEF_PERIOD,
  parameter int DEAD_TIME     = DEF_DEAD_TIME,
  parameter int DUTY_STEP     = DEF_DUTY_STEP
) (
  input logic            clock,
  input logic            reset_n,
  pwm_phase_bank_if.slave bus
);

  localparam int TW = thr_width(DUTY_WIDTH, DUTY_STEP, PERIOD);
  localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(PERIOD - 1);
  localparam logic [TW-1:0]            PERIOD_T = TW'(PERIOD);

  logic [COUNTER_WIDTH-1:0] counter;
  logic                     copy_now;
  logic                     period_start_q;
  logic [DUTY_WIDTH-1:0]    shadow [NUM_PHASES];
  logic [DUTY_WIDTH-1:0]    active [NUM_PHASES];
  logic [NUM_PHASES-1:0]    hi_v;
  logic [NUM_PHASES-1:0]    lo_v;

`ifdef PWM_CENTER_ALIGNED_EN
  logic count_up;

  // Triangle: the peak and the trough are each held for two cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counter        <= '0;
      count_up       <= 1'b1;
      period_start_q <= 1'b0;
    end else begin
      period_start_q <= !count_up && (counter == '0);
      if (count_up) begin
        if (counter == CNT_LAST) count_up <= 1'b0;
        else                     counter  <= counter + 1'b1;
      end else begin
        if (counter == '0) count_up <= 1'b1;
        else               counter  <= counter - 1'b1;
      end
    end
  end

  assign copy_now = !count_up && (counter == '0);
`else
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counter        <= '0;
      period_start_q <= 1'b0;
    end else begin
      counter        <= (counter == CNT_LAST) ? '0 : counter + 1'b1;
      period_start_q <= (counter == CNT_LAST);
    end
  end

  assign copy_now = (counter == CNT_LAST);
`endif

  // A load coinciding with the boundary copy bypasses the shadow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PHASES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PHASES; i++) begin
        if (bus.duty_load) shadow[i] <= bus.duty_in[i*DUTY_WIDTH +: DUTY_WIDTH];
        if (copy_now) begin
          active[i] <= bus.duty_load ? bus.duty_in[i*DUTY_WIDTH +: DUTY_WIDTH] : shadow[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PHASES; g++) begin : g_phase
    logic [TW-1:0] prod;
    logic [TW-1:0] thr;
    logic          hi_win;
    req_t          req;

    always_comb begin
      prod = TW'(active[g]) * TW'(DUTY_STEP);
      thr  = (prod >= PERIOD_T) ? PERIOD_T : prod;
    end

`ifdef PWM_CENTER_ALIGNED_EN
    assign hi_win = TW'(counter) >= (PERIOD_T - thr);
`else
    assign hi_win = TW'(counter) < thr;
`endif

    // Zero duty holds the low side on so the bootstrap capacitor stays charged.
    always_comb begin
      if (!bus.phase_en[g])     req = REQ_OFF;
      else if (bus.brake)       req = REQ_LO;
      else if (active[g] == '0) req = REQ_LO;
      else if (hi_win)          req = REQ_HI;
      else                      req = REQ_LO;
    end

    pwm_dead_time #(
      .DEAD_TIME (DEAD_TIME)
    ) u_dead_time (
      .clock   (clock),
      .reset_n (reset_n),
      .req     (req),
      .hi      (hi_v[g]),
      .lo      (lo_v[g])
    );
  end

  assign bus.pwm_hi       = hi_v;
  assign bus.pwm_lo       = lo_v;
  assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_pwm_phase_bank.sv
// Self-checking bench for pwm_phase_bank (edge-aligned build): directed steps plus random traffic
// compared every cycle against a run-length model of requests and dead time.
module tb_pwm_phase_bank;

  localparam int NP   = 3;
  localparam int DW   = 8;
  localparam int CW   = 7;
  localparam int P    = 100;
  localparam int D    = 4;
  localparam int STEP = 1;

  localparam int R_OFF = 0;
  localparam int R_HI  = 1;
  localparam int R_LO  = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  pwm_phase_bank_if #(.NUM_PHASES(NP), .DUTY_WIDTH(DW)) bus ();

  pwm_phase_bank #(
    .NUM_PHASES    (NP),
    .DUTY_WIDTH    (DW),
    .COUNTER_WIDTH (CW),
    .PERIOD        (P),
    .DEAD_TIME     (D),
    .DUTY_STEP     (STEP)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference state: position in period, duty registers, and per-phase request run lengths.
  int   mcnt;
  int   shadow   [NP];
  int   active   [NP];
  int   last_req [NP];
  int   run_len  [NP];
  logic exp_ps;
  int   hi_cnt   [NP];
  int   lo_cnt   [NP];

  task automatic check(input string tag, input logic [31:0] obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mcnt   = 0;
    exp_ps = 1'b0;
    for (int i = 0; i < NP; i++) begin
      shadow[i]   = 0;
      active[i]   = 0;
      last_req[i] = R_OFF;
      run_len[i]  = 0;
    end
  endtask

  function automatic int req_of(int i);
    int t;
    if (!bus.phase_en[i]) return R_OFF;
    if (bus.brake)        return R_LO;
    if (active[i] == 0)   return R_LO;
    t = active[i] * STEP;
    if (t > P) t = P;
    return (mcnt < t) ? R_HI : R_LO;
  endfunction

  task automatic clear_counts();
    for (int i = 0; i < NP; i++) begin
      hi_cnt[i] = 0;
      lo_cnt[i] = 0;
    end
  endtask

  // One clock edge: sample requests, advance the model, then check outputs #1 after the edge.
  // An output asserts only once its request has been unchanged for D+1 consecutive edges.
  task automatic step();
    int               r;
    int               d;
    logic             do_copy;
    logic [NP-1:0]    eh;
    logic [NP-1:0]    el;
    for (int i = 0; i < NP; i++) begin
      r = req_of(i);
      if (run_len[i] > 0 && r == last_req[i]) run_len[i]++;
      else begin
        last_req[i] = r;
        run_len[i]  = 1;
      end
    end
    do_copy = (mcnt == P - 1);
    for (int i = 0; i < NP; i++) begin
      d = int'(bus.duty_in[i*DW +: DW]);
      if (do_copy) active[i] = bus.duty_load ? d : shadow[i];
      if (bus.duty_load) shadow[i] = d;
    end
    exp_ps = do_copy;
    mcnt   = (mcnt + 1) % P;
    @(posedge clock);
    #1;
    for (int i = 0; i < NP; i++) begin
      eh[i] = (run_len[i] >= D + 1) && (last_req[i] == R_HI);
      el[i] = (run_len[i] >= D + 1) && (last_req[i] == R_LO);
      hi_cnt[i] += int'(bus.pwm_hi[i]);
      lo_cnt[i] += int'(bus.pwm_lo[i]);
    end
    check("pwm_hi", 32'(bus.pwm_hi), int'(eh));
    check("pwm_lo", 32'(bus.pwm_lo), int'(el));
    check("period_start", 32'(bus.period_start), int'(exp_ps));
    check("hi_lo_overlap", 32'(bus.pwm_hi & bus.pwm_lo), 0);
  endtask

  initial begin
    bus.duty_in   = '0;
    bus.duty_load = 1'b0;
    bus.phase_en  = '1;
    bus.brake     = 1'b0;
    model_reset();
    clear_counts();

    repeat (3) @(posedge clock);
    #1;
    check("reset_hi", 32'(bus.pwm_hi), 0);
    check("reset_lo", 32'(bus.pwm_lo), 0);
    check("reset_period_start", 32'(bus.period_start), 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Duty 0 everywhere: low side comes up on the fifth edge after release.
    repeat (4) step();
    check("lo_before_5th_edge", 32'(bus.pwm_lo), 0);
    step();
    check("lo_on_5th_edge", 32'(bus.pwm_lo), 7);
    repeat (100) step();

    // Phase 0 duty 30.
    bus.duty_in   = {8'd0, 8'd0, 8'd30};
    bus.duty_load = 1'b1;
    step();
    bus.duty_load = 1'b0;
    repeat (150) step();
    clear_counts();
    repeat (100) step();
    check("duty30_hi_cycles", 32'(hi_cnt[0]), 26);
    check("duty30_lo_cycles", 32'(lo_cnt[0]), 66);

    // Phase 1 duty 120 saturates: high side continuous.
    bus.duty_in   = {8'd0, 8'd120, 8'd30};
    bus.duty_load = 1'b1;
    step();
    bus.duty_load = 1'b0;
    repeat (150) step();
    clear_counts();
    repeat (100) step();
    check("duty120_hi_cycles", 32'(hi_cnt[1]), 100);
    check("duty120_lo_cycles", 32'(lo_cnt[1]), 0);

    // Mid-period load of 60 at counter 50: current period keeps 30.
    for (int n = 0; n < P && mcnt != 50; n++) step();
    bus.duty_in   = {8'd0, 8'd120, 8'd60};
    bus.duty_load = 1'b1;
    step();
    bus.duty_load = 1'b0;
    repeat (120) step();
    clear_counts();
    repeat (100) step();
    check("duty60_hi_cycles", 32'(hi_cnt[0]), 56);
    check("duty60_lo_cycles", 32'(lo_cnt[0]), 36);

    // Brake while phase 1 drives high.
    check("pre_brake_hi1", 32'(bus.pwm_hi[1]), 1);
    bus.brake = 1'b1;
    step();
    check("brake_hi_off", 32'(bus.pwm_hi), 0);
    repeat (3) step();
    check("brake_dead_lo1", 32'(bus.pwm_lo[1]), 0);
    step();
    check("brake_lo1_on", 32'(bus.pwm_lo[1]), 1);
    repeat (20) step();
    bus.brake = 1'b0;
    repeat (30) step();

    // Disable phase 1 mid-period.
    bus.phase_en = 3'b101;
    step();
    check("disable_phase1", 32'({bus.pwm_hi[1], bus.pwm_lo[1]}), 0);
    repeat (15) step();
    bus.phase_en = 3'b111;
    repeat (30) step();

    // Random traffic.
    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        for (int i = 0; i < NP; i++) bus.duty_in[i*DW +: DW] = DW'($urandom_range(0, 255));
        bus.duty_load = 1'b1;
      end else begin
        bus.duty_load = 1'b0;
      end
      if ($urandom_range(0, 59) == 0) bus.brake = ~bus.brake;
      if ($urandom_range(0, 39) == 0) bus.phase_en[$urandom_range(0, NP - 1)] ^= 1'b1;
      step();
    end
    bus.duty_load = 1'b0;

    // Asynchronous reset between edges.
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_hi", 32'(bus.pwm_hi), 0);
    check("async_reset_lo", 32'(bus.pwm_lo), 0);
    check("async_reset_period_start", 32'(bus.period_start), 0);
    model_reset();
    bus.brake    = 1'b0;
    bus.phase_en = '1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
